pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of performance counters.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: rs1_DE, rs2_DE  in  5 each  source registers of instruction in Decode.
REQ-005 SHALL have ports: rs1_EX, rs2_EX, rd_EX  in  5 each  Execute-stage register indices.
REQ-006 SHALL have ports: rf_write_en_EX, mem_read_en_EX  in  1 each  Execute-stage controls.
REQ-007 SHALL have ports: rd_MEM  in  5, and rf_write_en_MEM  in  1  Memory-stage writer.
REQ-008 SHALL have ports: rd_WB  in  5, and rf_write_en_WB  in  1  Writeback-stage writer.
REQ-009 SHALL have port: mispredict_EX  in  1  branch/JAL/JALR resolved in Execute, fetch redirected.
REQ-010 SHALL have ports: dmem_req_MEM  in  1  data access in Memory; dmem_ready  in  1  access completes this cycle.
REQ-011 SHALL have ports: stall_F, stall_DE, flush_DE, flush_EX, freeze  out  1 each  pipeline register controls.
REQ-012 SHALL have ports: forward_a_EX, forward_b_EX  out  2 each  00 rd1/rd2, 01 WB, 10 MEM, 11 unused.
REQ-013 SHALL have ports: state_o  out  2  FSM state; stall_cycles, flush_count  out  CNT_W each  counters.

Function
REQ-014 SHALL implement FSM: RUN=00, REDIRECT=01, MEM_WAIT=10; 11 unreachable, decodes as RUN.
REQ-015 SHALL compute freeze = dmem_req_MEM & !dmem_ready, any state; freeze forces stall_F=stall_DE=1, flush_DE=flush_EX=0.
REQ-016 SHALL transition to MEM_WAIT when freeze=1; MEM_WAIT holds until dmem_ready=1, then evaluates as RUN that same cycle.
REQ-017 SHALL, when not frozen and mispredict_EX=1: flush_DE=1, flush_EX=1, stall_F=stall_DE=0; next state REDIRECT.
REQ-018 SHALL, in REDIRECT and not frozen: flush_DE=1 (synchronous imem wrong-path fetch), flush_EX=0; return to RUN next cycle.
REQ-019 SHALL detect load-use (not frozen, no mispredict): mem_read_en_EX & rf_write_en_EX & rd_EX!=0 & (rd_EX==rs1_DE | rd_EX==rs2_DE).
REQ-020 SHALL, on load-use: stall_F=1, stall_DE=1, flush_EX=1 for exactly one cycle; state stays RUN.
REQ-021 SHALL use priority freeze > mispredict_EX > REDIRECT flush > load-use; mispredict in REDIRECT restarts REDIRECT.
REQ-022 SHALL select forward_a_EX=10 when rf_write_en_MEM & rd_MEM!=0 & rd_MEM==rs1_EX; else 01 if same test on WB; else 00.
REQ-023 SHALL apply REQ-022 identically to forward_b_EX with rs2_EX; MEM beats WB when both match.
REQ-024 SHALL generate all control outputs combinationally from state and current inputs, zero added latency.

Reset
REQ-025 SHALL, while rst=1, force state RUN, all 1-bit outputs 0, forward selects 00, counters 0, regardless of inputs.
REQ-026 SHALL abandon MEM_WAIT or REDIRECT immediately on rst mid-operation; first cycle after release is RUN.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cycles each cycle stall_DE=1 and flush_count each mispredict_EX accepted (not frozen).
REQ-028 SHALL saturate both counters at all-ones, never wrap.
REQ-029 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles and flush_count to 0 and instantiate no counter flops.

Verification
REQ-030 SHALL cover load-use: rd_EX=5, mem_read_en_EX=1, rf_write_en_EX=1, rs2_DE=5 -> one cycle stall_F=stall_DE=flush_EX=1, state_o=00.
REQ-031 SHALL cover x0: same as REQ-030 with rd_EX=0 -> no stall; rd_MEM=0 match -> forward 00.
REQ-032 SHALL cover forwarding: rd_MEM=rd_WB=7 writing, rs1_EX=7 -> forward_a_EX=10; rf_write_en_MEM=0 -> 01.
REQ-033 SHALL cover mispredict: mispredict_EX pulse -> flush_DE=flush_EX=1, next cycle flush_DE=1 only, state 01 then 00; flush_count +1.
REQ-034 SHALL cover memory wait: dmem_req_MEM=1, dmem_ready low 3 cycles, mispredict_EX=1 -> freeze 3 cycles, no flush, state 10; on ready, flush and state 01.
REQ-035 SHALL cover reset mid-MEM_WAIT: rst pulse -> all outputs 0 asynchronously, state_o=00 after release.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Groups the hazard-unit signals exchanged between the pipeline datapath and
// the hazard controller.
//   master : pipeline side, drives register indices / stage controls,
//            receives stall/flush/forward controls and counters.
//   slave  : controller side, the mirror image.
// Parameter CNT_W : width of the performance counters.
// -----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
   parameter int unsigned CNT_W = 32
);
   // Decode-stage sources
   logic [4:0]       rs1_DE;
   logic [4:0]       rs2_DE;
   // Execute stage
   logic [4:0]       rs1_EX;
   logic [4:0]       rs2_EX;
   logic [4:0]       rd_EX;
   logic             rf_write_en_EX;
   logic             mem_read_en_EX;
   logic             mispredict_EX;
   // Memory / writeback writers
   logic [4:0]       rd_MEM;
   logic             rf_write_en_MEM;
   logic [4:0]       rd_WB;
   logic             rf_write_en_WB;
   // Data memory handshake
   logic             dmem_req_MEM;
   logic             dmem_ready;
   // Controls back to the pipeline
   logic             stall_F;
   logic             stall_DE;
   logic             flush_DE;
   logic             flush_EX;
   logic             freeze;
   logic [1:0]       forward_a_EX;
   logic [1:0]       forward_b_EX;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output rs1_DE, rs2_DE, rs1_EX, rs2_EX, rd_EX, rf_write_en_EX, mem_read_en_EX,
             mispredict_EX, rd_MEM, rf_write_en_MEM, rd_WB, rf_write_en_WB,
             dmem_req_MEM, dmem_ready,
      input  stall_F, stall_DE, flush_DE, flush_EX, freeze, forward_a_EX, forward_b_EX,
             state_o, stall_cycles, flush_count
   );

   modport slave (
      input  rs1_DE, rs2_DE, rs1_EX, rs2_EX, rd_EX, rf_write_en_EX, mem_read_en_EX,
             mispredict_EX, rd_MEM, rf_write_en_MEM, rd_WB, rf_write_en_WB,
             dmem_req_MEM, dmem_ready,
      output stall_F, stall_DE, flush_DE, flush_EX, freeze, forward_a_EX, forward_b_EX,
             state_o, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Hazard unit for a 5-stage in-order pipeline: load-use stall, branch
// mispredict flush (with one extra wrong-path flush for the synchronous
// instruction memory), data-memory freeze, and EX operand forwarding.
// Ports:
//   clk - clock, all state on the rising edge
//   rst - asynchronous active-high reset
//   hz  - pipeline_hazard_controller_if.slave (stage info in, controls out)
// Parameter CNT_W : performance counter width.
// Macro HAZARD_PERF_CNT_EN : when defined, builds saturating stall_cycles /
//   flush_count counters; otherwise both read as zero and no flops exist.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
   parameter int unsigned CNT_W = 32
) (
   input logic                         clk,
   input logic                         rst,
   pipeline_hazard_controller_if.slave hz
);

   typedef enum logic [1:0] {
      StRun      = 2'b00,
      StRedirect = 2'b01,
      StMemWait  = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic       freeze;
   logic       load_use;
   logic       in_redirect;
   logic       stall_f, stall_de, flush_de, flush_ex;
   logic [1:0] fwd_a, fwd_b;

   assign freeze      = hz.dmem_req_MEM & ~hz.dmem_ready;
   // Only REDIRECT behaves differently; MEM_WAIT and the unused encoding act as RUN.
   assign in_redirect = (state_q == StRedirect);
   assign load_use    = hz.mem_read_en_EX & hz.rf_write_en_EX & (hz.rd_EX != 5'd0) &
                        ((hz.rd_EX == hz.rs1_DE) | (hz.rd_EX == hz.rs2_DE));

   // Priority: freeze > mispredict > redirect flush > load-use.
   always_comb begin
      stall_f  = 1'b0;
      stall_de = 1'b0;
      flush_de = 1'b0;
      flush_ex = 1'b0;
      state_d  = StRun;
      if (freeze) begin
         stall_f  = 1'b1;
         stall_de = 1'b1;
         state_d  = StMemWait;
      end else if (hz.mispredict_EX) begin
         flush_de = 1'b1;
         flush_ex = 1'b1;
         state_d  = StRedirect;
      end else if (in_redirect) begin
         // Synchronous imem delivers one more wrong-path instruction.
         flush_de = 1'b1;
      end else if (load_use) begin
         stall_f  = 1'b1;
         stall_de = 1'b1;
         flush_ex = 1'b1;
      end
   end

   // Forwarding: MEM is younger than WB, so it wins; x0 never forwards.
   always_comb begin
      fwd_a = 2'b00;
      if (hz.rf_write_en_MEM && hz.rd_MEM != 5'd0 && hz.rd_MEM == hz.rs1_EX) begin
         fwd_a = 2'b10;
      end else if (hz.rf_write_en_WB && hz.rd_WB != 5'd0 && hz.rd_WB == hz.rs1_EX) begin
         fwd_a = 2'b01;
      end
      fwd_b = 2'b00;
      if (hz.rf_write_en_MEM && hz.rd_MEM != 5'd0 && hz.rd_MEM == hz.rs2_EX) begin
         fwd_b = 2'b10;
      end else if (hz.rf_write_en_WB && hz.rd_WB != 5'd0 && hz.rd_WB == hz.rs2_EX) begin
         fwd_b = 2'b01;
      end
   end

   // Outputs are combinational; reset masks them immediately, not at the next edge.
   always_comb begin
      hz.stall_F      = stall_f  & ~rst;
      hz.stall_DE     = stall_de & ~rst;
      hz.flush_DE     = flush_de & ~rst;
      hz.flush_EX     = flush_ex & ~rst;
      hz.freeze       = freeze   & ~rst;
      hz.forward_a_EX = rst ? 2'b00 : fwd_a;
      hz.forward_b_EX = rst ? 2'b00 : fwd_b;
   end

   assign hz.state_o = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic [CNT_W-1:0] cnt_one;

   assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturate at all-ones instead of wrapping.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall_de && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + cnt_one;
      end
      if (hz.mispredict_EX && !freeze && !(&flush_count_q)) begin
         flush_count_d = flush_count_q + cnt_one;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_count  = flush_count_q;
`else
   assign hz.stall_cycles = {CNT_W{1'b0}};
   assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Table of single-cycle vectors plus hand-written multi-cycle sequences for
// mispredict redirect, memory wait and asynchronous reset. Expected outputs
// are queued when stimulus is driven and compared at the following negedge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

   typedef struct packed {
      logic [4:0] rs1_DE;
      logic [4:0] rs2_DE;
      logic [4:0] rs1_EX;
      logic [4:0] rs2_EX;
      logic [4:0] rd_EX;
      logic       we_EX;
      logic       mr_EX;
      logic [4:0] rd_MEM;
      logic       we_MEM;
      logic [4:0] rd_WB;
      logic       we_WB;
      logic       mispredict;
      logic       dmem_req;
      logic       dmem_ready;
   } in_t;

   typedef struct packed {
      logic [1:0] state;
      logic       stall_F;
      logic       stall_DE;
      logic       flush_DE;
      logic       flush_EX;
      logic       freeze;
      logic [1:0] fwd_a;
      logic [1:0] fwd_b;
   } out_t;

   typedef struct {
      in_t   i;
      out_t  o;
      string name;
   } vec_t;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_hazard_controller_if #(.CNT_W(32)) hz ();

   pipeline_hazard_controller #(.CNT_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;
   out_t  exp_q[$];
   string name_q[$];
   vec_t  vecs[14];

   localparam in_t  Idle  = '0;
   localparam out_t Quiet = '0;

   task automatic drive(input in_t i);
      hz.rs1_DE          = i.rs1_DE;
      hz.rs2_DE          = i.rs2_DE;
      hz.rs1_EX          = i.rs1_EX;
      hz.rs2_EX          = i.rs2_EX;
      hz.rd_EX           = i.rd_EX;
      hz.rf_write_en_EX  = i.we_EX;
      hz.mem_read_en_EX  = i.mr_EX;
      hz.rd_MEM          = i.rd_MEM;
      hz.rf_write_en_MEM = i.we_MEM;
      hz.rd_WB           = i.rd_WB;
      hz.rf_write_en_WB  = i.we_WB;
      hz.mispredict_EX   = i.mispredict;
      hz.dmem_req_MEM    = i.dmem_req;
      hz.dmem_ready      = i.dmem_ready;
   endtask

   function automatic out_t sample();
      out_t s;
      s.state    = hz.state_o;
      s.stall_F  = hz.stall_F;
      s.stall_DE = hz.stall_DE;
      s.flush_DE = hz.flush_DE;
      s.flush_EX = hz.flush_EX;
      s.freeze   = hz.freeze;
      s.fwd_a    = hz.forward_a_EX;
      s.fwd_b    = hz.forward_b_EX;
      return s;
   endfunction

   task automatic check_pop();
      out_t  e;
      out_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = sample();
      n_vec++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got st=%b sF=%b sD=%b fD=%b fE=%b frz=%b fa=%b fb=%b, want st=%b sF=%b sD=%b fD=%b fE=%b frz=%b fa=%b fb=%b",
                  nm, a.state, a.stall_F, a.stall_DE, a.flush_DE, a.flush_EX, a.freeze,
                  a.fwd_a, a.fwd_b, e.state, e.stall_F, e.stall_DE, e.flush_DE, e.flush_EX,
                  e.freeze, e.fwd_a, e.fwd_b);
      end
   endtask

   task automatic cmp_cnt(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // One pipeline cycle: drive after the edge, compare mid-cycle, then update
   // the counter model for the edge that closes this cycle.
   task automatic apply(input in_t i, input out_t e, input string nm);
      @(posedge clk);
      #1;
      drive(i);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      check_pop();
      if (e.stall_DE) exp_stall++;
      if (i.mispredict && !e.freeze) exp_flush++;
   endtask

   task automatic check_counters(input string nm);
      @(posedge clk);
      #1;
      drive(Idle);
      cmp_cnt({nm, " stall_cycles"}, hz.stall_cycles, CntEn ? exp_stall : 32'd0);
      cmp_cnt({nm, " flush_count"}, hz.flush_count, CntEn ? exp_flush : 32'd0);
   endtask

   in_t lu;   // load-use pattern on rs2
   in_t frz;  // frozen memory access with mispredict

   initial begin
      lu  = in_t'{rd_EX: 5'd5, mr_EX: 1'b1, we_EX: 1'b1, rs2_DE: 5'd5, default: '0};
      frz = in_t'{dmem_req: 1'b1, dmem_ready: 1'b0, mispredict: 1'b1, default: '0};

      vecs[0]  = '{Idle, Quiet, "idle"};
      vecs[1]  = '{lu, out_t'{stall_F: 1'b1, stall_DE: 1'b1, flush_EX: 1'b1, default: '0},
                   "loaduse_rs2"};
      vecs[2]  = '{in_t'{rd_EX: 5'd9, mr_EX: 1'b1, we_EX: 1'b1, rs1_DE: 5'd9, default: '0},
                   out_t'{stall_F: 1'b1, stall_DE: 1'b1, flush_EX: 1'b1, default: '0},
                   "loaduse_rs1"};
      vecs[3]  = '{in_t'{rd_EX: 5'd0, mr_EX: 1'b1, we_EX: 1'b1, rs2_DE: 5'd0, default: '0},
                   Quiet, "loaduse_x0"};
      vecs[4]  = '{in_t'{rd_EX: 5'd5, we_EX: 1'b1, rs1_DE: 5'd5, default: '0},
                   Quiet, "alu_no_stall"};
      vecs[5]  = '{in_t'{rd_EX: 5'd5, mr_EX: 1'b1, we_EX: 1'b1, rs1_DE: 5'd6, rs2_DE: 5'd4,
                         default: '0}, Quiet, "load_no_match"};
      vecs[6]  = '{in_t'{rd_MEM: 5'd7, we_MEM: 1'b1, rd_WB: 5'd7, we_WB: 1'b1, rs1_EX: 5'd7,
                         default: '0}, out_t'{fwd_a: 2'b10, default: '0}, "fwd_mem_beats_wb"};
      vecs[7]  = '{in_t'{rd_MEM: 5'd7, we_MEM: 1'b0, rd_WB: 5'd7, we_WB: 1'b1, rs1_EX: 5'd7,
                         default: '0}, out_t'{fwd_a: 2'b01, default: '0}, "fwd_wb"};
      vecs[8]  = '{in_t'{rd_MEM: 5'd0, we_MEM: 1'b1, rd_WB: 5'd0, we_WB: 1'b1, default: '0},
                   Quiet, "fwd_x0"};
      vecs[9]  = '{in_t'{rd_MEM: 5'd3, we_MEM: 1'b1, rs2_EX: 5'd3, rd_WB: 5'd4, we_WB: 1'b1,
                         rs1_EX: 5'd4, default: '0},
                   out_t'{fwd_a: 2'b01, fwd_b: 2'b10, default: '0}, "fwd_both"};
      vecs[10] = '{in_t'{rd_EX: 5'd5, mr_EX: 1'b1, we_EX: 1'b1, rs2_DE: 5'd5, dmem_req: 1'b1,
                         dmem_ready: 1'b0, default: '0},
                   out_t'{stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1, default: '0},
                   "freeze_over_loaduse"};
      vecs[11] = '{in_t'{rd_EX: 5'd5, mr_EX: 1'b1, we_EX: 1'b1, rs2_DE: 5'd5, dmem_req: 1'b1,
                         dmem_ready: 1'b1, default: '0},
                   out_t'{state: 2'b10, stall_F: 1'b1, stall_DE: 1'b1, flush_EX: 1'b1,
                          default: '0}, "memwait_ready_loaduse"};
      vecs[12] = '{in_t'{dmem_req: 1'b1, dmem_ready: 1'b0, rd_MEM: 5'd2, we_MEM: 1'b1,
                         rs2_EX: 5'd2, default: '0},
                   out_t'{stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1, fwd_b: 2'b10,
                          default: '0}, "freeze_with_fwd"};
      vecs[13] = '{Idle, out_t'{state: 2'b10, default: '0}, "memwait_release_idle"};

      // Reset holds every output low even with hazards on the inputs.
      drive(in_t'{dmem_req: 1'b1, mispredict: 1'b1, rd_EX: 5'd5, mr_EX: 1'b1, we_EX: 1'b1,
                  rs2_DE: 5'd5, rd_MEM: 5'd1, we_MEM: 1'b1, rs1_EX: 5'd1, default: '0});
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(Quiet);
      name_q.push_back("reset_outputs");
      check_pop();
      cmp_cnt("reset stall_cycles", hz.stall_cycles, 32'd0);
      drive(Idle);
      rst = 1'b0;

      for (int k = 0; k < 14; k++) begin
         apply(vecs[k].i, vecs[k].o, vecs[k].name);
      end
      check_counters("table");

      // Mispredict: flush both, then one DE-only flush in REDIRECT.
      apply(in_t'{mispredict: 1'b1, default: '0},
            out_t'{flush_DE: 1'b1, flush_EX: 1'b1, default: '0}, "mp_accept");
      apply(Idle, out_t'{state: 2'b01, flush_DE: 1'b1, default: '0}, "mp_redirect");
      apply(Idle, Quiet, "mp_back_to_run");
      check_counters("mispredict");

      // Back-to-back mispredict restarts REDIRECT; REDIRECT beats load-use.
      apply(in_t'{mispredict: 1'b1, default: '0},
            out_t'{flush_DE: 1'b1, flush_EX: 1'b1, default: '0}, "mp2_first");
      apply(in_t'{mispredict: 1'b1, default: '0},
            out_t'{state: 2'b01, flush_DE: 1'b1, flush_EX: 1'b1, default: '0}, "mp2_restart");
      apply(lu, out_t'{state: 2'b01, flush_DE: 1'b1, default: '0}, "redirect_over_loaduse");
      apply(Idle, Quiet, "mp2_done");

      // Memory wait with a pending mispredict: freeze wins until ready.
      apply(frz, out_t'{stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1, default: '0}, "mw_1");
      apply(frz, out_t'{state: 2'b10, stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1,
                        default: '0}, "mw_2");
      apply(frz, out_t'{state: 2'b10, stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1,
                        default: '0}, "mw_3");
      apply(in_t'{dmem_req: 1'b1, dmem_ready: 1'b1, mispredict: 1'b1, default: '0},
            out_t'{state: 2'b10, flush_DE: 1'b1, flush_EX: 1'b1, default: '0}, "mw_ready_mp");
      apply(Idle, out_t'{state: 2'b01, flush_DE: 1'b1, default: '0}, "mw_redirect");
      apply(Idle, Quiet, "mw_run");
      check_counters("memwait");

      // Asynchronous reset in the middle of MEM_WAIT.
      apply(frz, out_t'{stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1, default: '0}, "rmw_1");
      apply(frz, out_t'{state: 2'b10, stall_F: 1'b1, stall_DE: 1'b1, freeze: 1'b1,
                        default: '0}, "rmw_2");
      #2;
      rst = 1'b1;
      #1;
      exp_q.push_back(Quiet);
      name_q.push_back("rmw_async_reset");
      check_pop();
      cmp_cnt("rmw stall_cycles", hz.stall_cycles, 32'd0);
      cmp_cnt("rmw flush_count", hz.flush_count, 32'd0);
      exp_stall = 0;
      exp_flush = 0;
      @(posedge clk);
      #1;
      drive(Idle);
      rst = 1'b0;
      #1;
      exp_q.push_back(Quiet);
      name_q.push_back("rmw_after_release");
      check_pop();
      apply(Idle, Quiet, "rmw_run");
      check_counters("rmw");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
